// File: rtl/snoop_cache_ctrl.sv
// Direct-mapped, write-back, MSI snooping cache controller.
// One CPU port, one bus-master port, and a snoop port that watches the other
// processors' commands. The snoop path runs every cycle, independent of the
// CPU FSM, and its effect on a line is applied before any same-cycle CPU update.
module snoop_cache_ctrl #(
    parameter int LINES  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 8,
    parameter int PID_W  = 2,
    parameter int MY_ID  = 0
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              cpu_req,
    input  logic                              cpu_op,
    input  logic [$clog2(LINES)-1:0]          cpu_index,
    input  logic [TAG_W-1:0]                  cpu_tag,
    input  logic [DATA_W-1:0]                 cpu_wdata,
    output logic                              cpu_ack,
    output logic                              cpu_hit,
    output logic [DATA_W-1:0]                 cpu_rdata,
    output logic                              bus_req,
    input  logic                              bus_gnt,
    output logic [2:0]                        bus_cmd,
    output logic [TAG_W+$clog2(LINES)-1:0]    bus_addr,
    output logic [DATA_W-1:0]                 bus_wdata,
    output logic [PID_W-1:0]                  bus_src,
    input  logic                              fill_valid,
    input  logic [DATA_W-1:0]                 fill_data,
    input  logic                              snoop_valid,
    input  logic [2:0]                        snoop_cmd,
    input  logic [TAG_W+$clog2(LINES)-1:0]    snoop_addr,
    input  logic [PID_W-1:0]                  snoop_src,
    output logic                              snoop_hit,
    output logic                              snoop_flush,
    output logic [DATA_W-1:0]                 snoop_data
);

    localparam int IW = $clog2(LINES);
    localparam logic [PID_W-1:0] MY_PID = PID_W'(MY_ID);

    localparam logic [2:0] CMD_NONE = 3'b000;
    localparam logic [2:0] CMD_RD   = 3'b001;
    localparam logic [2:0] CMD_RDX  = 3'b010;
    localparam logic [2:0] CMD_UPGR = 3'b011;
    localparam logic [2:0] CMD_WB   = 3'b100;

    typedef enum logic [1:0] {
        LS_I = 2'b00,
        LS_S = 2'b01,
        LS_M = 2'b10
    } lstate_t;

    typedef enum logic [2:0] {
        IDLE, WB_ARB, WB_BUS, ARB, BUS, FILL, RESP
    } fsm_t;

    // Line storage
    lstate_t           line_state [LINES];
    logic [TAG_W-1:0]  line_tag   [LINES];
    logic [DATA_W-1:0] line_data  [LINES];

    // Controller registers
    fsm_t              state, state_n;
    logic [2:0]        pend_cmd, pend_n;
    logic              resp_hit, resp_hit_n;
    logic [DATA_W-1:0] resp_data, resp_data_n;

    // CPU-side line write controls (always target cpu_index)
    logic              ls_we;
    lstate_t           ls_wd;
    logic              tag_we;
    logic              data_we;
    logic [DATA_W-1:0] data_wd;

    // Snoop decode
    logic [IW-1:0]     snp_idx;
    logic [TAG_W-1:0]  snp_tag;
    logic              snp_match;
    logic              snp_upd;
    lstate_t           snp_state_nx;
    logic              snp_flush_nx;

    // CPU view of its line after this cycle's snoop has been applied
    lstate_t           cpu_ps_state;
    logic              cpu_line_hit;

    assign bus_src = MY_PID;

    assign snp_idx   = snoop_addr[IW-1:0];
    assign snp_tag   = snoop_addr[IW +: TAG_W];
    assign snp_match = snoop_valid && (snoop_src != MY_PID) &&
                       (line_state[snp_idx] != LS_I) && (line_tag[snp_idx] == snp_tag);

    // Snoop response: MSI downgrade/invalidate and flush decision for the snooped line
    always_comb begin
        snp_upd      = 1'b0;
        snp_state_nx = line_state[snp_idx];
        snp_flush_nx = 1'b0;
        if (snp_match) begin
            case (snoop_cmd)
                CMD_RD: begin
                    if (line_state[snp_idx] == LS_M) begin
                        snp_upd      = 1'b1;
                        snp_state_nx = LS_S;
                        snp_flush_nx = 1'b1;
                    end
                end
                CMD_RDX: begin
                    snp_upd      = 1'b1;
                    snp_state_nx = LS_I;
                    snp_flush_nx = (line_state[snp_idx] == LS_M);
                end
                CMD_UPGR: begin
                    if (line_state[snp_idx] == LS_S) begin
                        snp_upd      = 1'b1;
                        snp_state_nx = LS_I;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_ps_state = (snp_upd && (snp_idx == cpu_index)) ? snp_state_nx
                                                               : line_state[cpu_index];
    assign cpu_line_hit = (cpu_ps_state != LS_I) && (line_tag[cpu_index] == cpu_tag);

    // Controller state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pend_cmd  <= CMD_NONE;
            resp_hit  <= 1'b0;
            resp_data <= '0;
        end else begin
            state     <= state_n;
            pend_cmd  <= pend_n;
            resp_hit  <= resp_hit_n;
            resp_data <= resp_data_n;
        end
    end

    // Controller next state and CPU-side line updates
    always_comb begin
        state_n     = state;
        pend_n      = pend_cmd;
        resp_hit_n  = resp_hit;
        resp_data_n = resp_data;
        ls_we       = 1'b0;
        ls_wd       = LS_I;
        tag_we      = 1'b0;
        data_we     = 1'b0;
        data_wd     = '0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_line_hit && (!cpu_op || (cpu_ps_state == LS_M))) begin
                        resp_hit_n = 1'b1;
                        state_n    = RESP;
                        if (cpu_op) begin
                            data_we     = 1'b1;
                            data_wd     = cpu_wdata;
                            resp_data_n = cpu_wdata;
                        end else begin
                            resp_data_n = line_data[cpu_index];
                        end
                    end else if (cpu_line_hit) begin
                        resp_hit_n = 1'b0;
                        pend_n     = CMD_UPGR;
                        state_n    = ARB;
                    end else begin
                        resp_hit_n = 1'b0;
                        pend_n     = cpu_op ? CMD_RDX : CMD_RD;
                        state_n    = (cpu_ps_state == LS_M) ? WB_ARB : ARB;
                    end
                end
            end
            WB_ARB: begin
                // A snoop may have already taken the dirty victim away
                if (cpu_ps_state != LS_M) begin
                    state_n = ARB;
                end else if (bus_gnt) begin
                    state_n = WB_BUS;
                end
            end
            WB_BUS: begin
                ls_we   = 1'b1;
                ls_wd   = LS_I;
                state_n = ARB;
            end
            ARB: begin
                // Upgrade target lost to a snoop: fall back to a full read-exclusive
                if ((pend_cmd == CMD_UPGR) && !cpu_line_hit) begin
                    pend_n = CMD_RDX;
                end
                if (bus_gnt) begin
                    state_n = BUS;
                end
            end
            BUS: begin
                if (pend_cmd == CMD_UPGR) begin
                    ls_we       = 1'b1;
                    ls_wd       = LS_M;
                    data_we     = 1'b1;
                    data_wd     = cpu_wdata;
                    resp_data_n = cpu_wdata;
                    state_n     = RESP;
                end else begin
                    state_n = FILL;
                end
            end
            FILL: begin
                if (fill_valid) begin
                    ls_we       = 1'b1;
                    ls_wd       = cpu_op ? LS_M : LS_S;
                    tag_we      = 1'b1;
                    data_we     = 1'b1;
                    data_wd     = cpu_op ? cpu_wdata : fill_data;
                    resp_data_n = cpu_op ? cpu_wdata : fill_data;
                    state_n     = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Line array: snoop update first, CPU update overrides on the same line
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LINES; i++) begin
                line_state[i] <= LS_I;
                line_tag[i]   <= '0;
                line_data[i]  <= '0;
            end
        end else begin
            if (snp_upd) begin
                line_state[snp_idx] <= snp_state_nx;
            end
            if (ls_we) begin
                line_state[cpu_index] <= ls_wd;
            end
            if (tag_we) begin
                line_tag[cpu_index] <= cpu_tag;
            end
            if (data_we) begin
                line_data[cpu_index] <= data_wd;
            end
        end
    end

    // Registered snoop response, valid the cycle after snoop_valid
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snoop_hit   <= 1'b0;
            snoop_flush <= 1'b0;
            snoop_data  <= '0;
        end else begin
            snoop_hit   <= snp_match;
            snoop_flush <= snp_flush_nx;
            snoop_data  <= snp_flush_nx ? line_data[snp_idx] : '0;
        end
    end

    // CPU and bus outputs decoded from the controller state
    always_comb begin
        cpu_ack   = 1'b0;
        cpu_hit   = 1'b0;
        cpu_rdata = '0;
        bus_req   = 1'b0;
        bus_cmd   = CMD_NONE;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            WB_ARB, ARB: begin
                bus_req = 1'b1;
            end
            WB_BUS: begin
                bus_cmd   = CMD_WB;
                bus_addr  = {line_tag[cpu_index], cpu_index};
                bus_wdata = line_data[cpu_index];
            end
            BUS: begin
                bus_cmd  = pend_cmd;
                bus_addr = {cpu_tag, cpu_index};
            end
            RESP: begin
                cpu_ack   = 1'b1;
                cpu_hit   = resp_hit;
                cpu_rdata = resp_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// Scoreboard bench for snoop_cache_ctrl: expected bus commands, CPU responses
// and snoop responses are queued as stimulus is issued and checked by monitors.
module tb_snoop_cache_ctrl;

    localparam int LINES  = 4;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 8;
    localparam int PID_W  = 2;
    localparam int MY_ID  = 1;
    localparam int IW     = 2;
    localparam int AW     = TAG_W + IW;

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_RD   = 3'b001;
    localparam logic [2:0] C_RDX  = 3'b010;
    localparam logic [2:0] C_UPGR = 3'b011;
    localparam logic [2:0] C_WB   = 3'b100;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              cpu_req = 1'b0;
    logic              cpu_op = 1'b0;
    logic [IW-1:0]     cpu_index = '0;
    logic [TAG_W-1:0]  cpu_tag = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic              cpu_hit;
    logic [DATA_W-1:0] cpu_rdata;
    logic              bus_req;
    logic              bus_gnt = 1'b0;
    logic [2:0]        bus_cmd;
    logic [AW-1:0]     bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [PID_W-1:0]  bus_src;
    logic              fill_valid = 1'b0;
    logic [DATA_W-1:0] fill_data = '0;
    logic              snoop_valid = 1'b0;
    logic [2:0]        snoop_cmd = '0;
    logic [AW-1:0]     snoop_addr = '0;
    logic [PID_W-1:0]  snoop_src = '0;
    logic              snoop_hit;
    logic              snoop_flush;
    logic [DATA_W-1:0] snoop_data;

    typedef struct packed {
        logic [2:0]        cmd;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } bus_exp_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } cpu_exp_t;

    typedef struct packed {
        logic              hit;
        logic              flush;
        logic [DATA_W-1:0] data;
    } snp_exp_t;

    bus_exp_t bus_q[$];
    cpu_exp_t cpu_q[$];
    snp_exp_t snp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int req_cycles = 0;
    int lat;
    int wait_n;
    int req_before;
    logic gnt_en = 1'b1;
    logic fill_en = 1'b1;
    logic [DATA_W-1:0] fill_val = '0;

    snoop_cache_ctrl #(
        .LINES(LINES), .TAG_W(TAG_W), .DATA_W(DATA_W), .PID_W(PID_W), .MY_ID(MY_ID)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_index(cpu_index), .cpu_tag(cpu_tag),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_src(bus_src),
        .fill_valid(fill_valid), .fill_data(fill_data),
        .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
        .snoop_src(snoop_src), .snoop_hit(snoop_hit), .snoop_flush(snoop_flush),
        .snoop_data(snoop_data)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] mk_addr(input logic [TAG_W-1:0] tag, input logic [IW-1:0] idx);
        return {tag, idx};
    endfunction

    task automatic exp_bus(input logic [2:0] cmd, input logic [AW-1:0] addr, input logic [DATA_W-1:0] data);
        bus_exp_t e;
        e.cmd = cmd; e.addr = addr; e.data = data;
        bus_q.push_back(e);
    endtask

    task automatic exp_cpu(input logic hit, input logic [DATA_W-1:0] data);
        cpu_exp_t e;
        e.hit = hit; e.data = data;
        cpu_q.push_back(e);
    endtask

    task automatic exp_snp(input logic hit, input logic flush, input logic [DATA_W-1:0] data);
        snp_exp_t e;
        e.hit = hit; e.flush = flush; e.data = data;
        snp_q.push_back(e);
    endtask

    // One CPU transaction; returns cycles from request to the ack sample
    task automatic cpu_access(input logic op, input logic [IW-1:0] idx, input logic [TAG_W-1:0] tag,
                              input logic [DATA_W-1:0] wd, output int cycles);
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_op = op; cpu_index = idx; cpu_tag = tag; cpu_wdata = wd;
        cycles = 0;
        do begin
            @(negedge clock);
            cycles++;
        end while (!cpu_ack && cycles < 60);
        check_eq("cpu_ack_seen", cpu_ack, 1);
        @(posedge clock); #1;
        cpu_req = 1'b0;
    endtask

    task automatic do_snoop(input logic [2:0] cmd, input logic [AW-1:0] addr, input logic [PID_W-1:0] src);
        @(posedge clock); #1;
        snoop_valid = 1'b1; snoop_cmd = cmd; snoop_addr = addr; snoop_src = src;
        @(posedge clock); #1;
        snoop_valid = 1'b0; snoop_cmd = '0; snoop_addr = '0; snoop_src = '0;
    endtask

    // Arbiter model: grant whenever requested and enabled
    initial forever begin
        @(negedge clock);
        if (bus_req) req_cycles++;
        bus_gnt = bus_req && gnt_en;
    end

    // Memory model: answer BusRd/BusRdX with fill data two cycles later
    initial forever begin
        @(negedge clock);
        if (fill_en && (bus_cmd == C_RD || bus_cmd == C_RDX)) begin
            repeat (2) @(posedge clock);
            #1;
            fill_valid = 1'b1; fill_data = fill_val;
            @(posedge clock); #1;
            fill_valid = 1'b0; fill_data = '0;
        end
    end

    // Bus monitor
    initial begin
        bus_exp_t be;
        forever begin
            @(negedge clock);
            if (bus_cmd != C_NONE) begin
                if (bus_q.size() == 0) begin
                    check_eq("bus_unexpected_cmd", bus_cmd, C_NONE);
                end else begin
                    be = bus_q.pop_front();
                    check_eq("bus_cmd", bus_cmd, be.cmd);
                    check_eq("bus_addr", bus_addr, be.addr);
                    if (be.cmd == C_WB) check_eq("bus_wdata", bus_wdata, be.data);
                    check_eq("bus_src", bus_src, MY_ID);
                end
            end
        end
    end

    // CPU response monitor
    initial begin
        cpu_exp_t ce;
        forever begin
            @(negedge clock);
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    check_eq("cpu_unexpected_ack", cpu_ack, 0);
                end else begin
                    ce = cpu_q.pop_front();
                    check_eq("cpu_hit", cpu_hit, ce.hit);
                    check_eq("cpu_rdata", cpu_rdata, ce.data);
                end
            end
        end
    end

    // Snoop response monitor: one cycle after each snoop_valid, zero otherwise
    initial begin
        snp_exp_t se;
        logic seen;
        forever begin
            @(posedge clock);
            seen = snoop_valid;
            @(negedge clock);
            if (seen) begin
                if (snp_q.size() == 0) begin
                    check_eq("snoop_no_expectation", 1, 0);
                end else begin
                    se = snp_q.pop_front();
                    check_eq("snoop_hit", snoop_hit, se.hit);
                    check_eq("snoop_flush", snoop_flush, se.flush);
                    check_eq("snoop_data", snoop_data, se.data);
                end
            end else if (snoop_hit || snoop_flush || (snoop_data != '0)) begin
                check_eq("snoop_idle_outputs", {snoop_hit, snoop_flush, snoop_data}, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check_eq("rst_cpu_ack", cpu_ack, 0);
        check_eq("rst_bus_req", bus_req, 0);
        check_eq("rst_bus_cmd", bus_cmd, 0);
        check_eq("rst_bus_addr", bus_addr, 0);
        check_eq("rst_snoop_hit", snoop_hit, 0);
        check_eq("rst_snoop_flush", snoop_flush, 0);
        check_eq("rst_bus_src", bus_src, MY_ID);
        @(posedge clock); #1;
        reset = 1'b1;

        // Read miss -> BusRd {5,1}, fill 0x3C, line S
        fill_val = 8'h3C;
        exp_bus(C_RD, mk_addr(5, 1), 0);
        exp_cpu(0, 8'h3C);
        cpu_access(0, 1, 5, 0, lat);

        // Repeat read hits with no bus activity
        req_before = req_cycles;
        exp_cpu(1, 8'h3C);
        cpu_access(0, 1, 5, 0, lat);
        check_eq("hit_latency", lat, 2);
        check_eq("hit_no_bus_req", req_cycles - req_before, 0);

        // Write hit in S -> BusUpgr, line M 0x77
        exp_bus(C_UPGR, mk_addr(5, 1), 0);
        exp_cpu(0, 8'h77);
        cpu_access(1, 1, 5, 8'h77, lat);

        // Snoop BusRd on M flushes and downgrades; BusRdX on S invalidates
        exp_snp(1, 1, 8'h77);
        do_snoop(C_RD, mk_addr(5, 1), 2);
        exp_snp(1, 0, 0);
        do_snoop(C_RDX, mk_addr(5, 1), 2);
        exp_snp(0, 0, 0);
        do_snoop(C_RD, mk_addr(5, 1), 2);

        // Write miss -> BusRdX, line M with write data (fill data ignored)
        fill_val = 8'hAA;
        exp_bus(C_RDX, mk_addr(5, 1), 0);
        exp_cpu(0, 8'h77);
        cpu_access(1, 1, 5, 8'h77, lat);

        // Conflict miss on dirty line: WriteBack {5,1} then BusRd {9,1}
        fill_val = 8'h42;
        exp_bus(C_WB, mk_addr(5, 1), 8'h77);
        exp_bus(C_RD, mk_addr(9, 1), 0);
        exp_cpu(0, 8'h42);
        cpu_access(0, 1, 9, 0, lat);

        // Own-id snoop is ignored; line still hits
        exp_snp(0, 0, 0);
        do_snoop(C_RDX, mk_addr(9, 1), MY_ID);
        exp_cpu(1, 8'h42);
        cpu_access(0, 1, 9, 0, lat);
        check_eq("own_snoop_hit_latency", lat, 2);

        // Upgrade pending in ARB loses the line to a snoop BusUpgr -> BusRdX
        gnt_en = 1'b0;
        fill_val = 8'h11;
        exp_bus(C_RDX, mk_addr(9, 1), 0);
        exp_cpu(0, 8'h5A);
        fork
            cpu_access(1, 1, 9, 8'h5A, lat);
            begin
                wait_n = 0;
                while (!bus_req && wait_n < 20) begin
                    @(negedge clock);
                    wait_n++;
                end
                check_eq("upg_arb_req", bus_req, 1);
                exp_snp(1, 0, 0);
                do_snoop(C_UPGR, mk_addr(9, 1), 2);
                gnt_en = 1'b1;
            end
        join
        exp_snp(1, 1, 8'h5A);
        do_snoop(C_RD, mk_addr(9, 1), 3);

        // Write miss then write hit in M (no bus), then read hit
        fill_val = 8'h00;
        exp_bus(C_RDX, mk_addr(3, 2), 0);
        exp_cpu(0, 8'h66);
        cpu_access(1, 2, 3, 8'h66, lat);
        req_before = req_cycles;
        exp_cpu(1, 8'h99);
        cpu_access(1, 2, 3, 8'h99, lat);
        check_eq("wr_hit_m_latency", lat, 2);
        check_eq("wr_hit_m_no_bus_req", req_cycles - req_before, 0);
        exp_cpu(1, 8'h99);
        cpu_access(0, 2, 3, 0, lat);

        // Highest index and tag
        fill_val = 8'hFF;
        exp_bus(C_RD, mk_addr(31, 3), 0);
        exp_cpu(0, 8'hFF);
        cpu_access(0, 3, 31, 0, lat);

        // Reset during FILL aborts the transaction
        fill_en = 1'b0;
        exp_bus(C_RD, mk_addr(7, 0), 0);
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_op = 1'b0; cpu_index = 0; cpu_tag = 7;
        wait_n = 0;
        while (bus_cmd == C_NONE && wait_n < 40) begin
            @(negedge clock);
            wait_n++;
        end
        check_eq("abort_busrd_seen", bus_cmd, C_RD);
        @(posedge clock); #1;
        reset = 1'b0;
        cpu_req = 1'b0;
        @(negedge clock);
        check_eq("abort_cpu_ack", cpu_ack, 0);
        check_eq("abort_bus_cmd", bus_cmd, 0);
        check_eq("abort_bus_req", bus_req, 0);
        check_eq("abort_bus_src", bus_src, MY_ID);
        for (int i = 0; i < LINES; i++) begin
            check_eq("abort_line_state", dut.line_state[i], 0);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        fill_en = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("post_abort_cpu_ack", cpu_ack, 0);

        // Previously valid line now misses
        fill_val = 8'h21;
        exp_bus(C_RD, mk_addr(9, 1), 0);
        exp_cpu(0, 8'h21);
        cpu_access(0, 1, 9, 0, lat);

        repeat (5) @(negedge clock);
        check_eq("bus_q_drained", bus_q.size(), 0);
        check_eq("cpu_q_drained", cpu_q.size(), 0);
        check_eq("snp_q_drained", snp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
